// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Digit moduli, BCD width and the load clamp helper live here.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam int BCD_W   = 4;
    localparam int MOD_DEC = 10;
    localparam int MOD_SEX = 6;

    function automatic logic [BCD_W-1:0] clamp_bcd(
        input logic [BCD_W-1:0] v,
        input logic [BCD_W-1:0] max_v
    );
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with modulo wrap and borrow chaining.
// The lowest digit of the chain is fed borrow_in=1 to request a decrement.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             borrow_in,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (en && borrow_in) begin
            digit_d = (digit_q == '0) ? BCD_W'(MOD - 1) : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = (digit_q == '0) && borrow_in;

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer driven by a 1 Hz tick, with done pulse and alarm.
// Four chained BCD digits hold the count; a 4-state FSM sequences it.
module countdown_timer_mmss
    import timer_pkg::*;
#(
    parameter int ALARM_SECONDS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [BCD_W-1:0] load_min_t,
    input  logic [BCD_W-1:0] load_min_u,
    input  logic [BCD_W-1:0] load_sec_t,
    input  logic [BCD_W-1:0] load_sec_u,
    output logic [BCD_W-1:0] min_t,
    output logic [BCD_W-1:0] min_u,
    output logic [BCD_W-1:0] sec_t,
    output logic [BCD_W-1:0] sec_u,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam logic [3:0] ALARM_LIM = 4'(ALARM_SECONDS);

    state_e     state_q, state_d;
    logic [3:0] acnt_q, acnt_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;

    logic dec, load_ok, is_zero, is_one;
    logic b_su, b_st, b_mu;

    assign dec     = (state_q == ST_RUN) && tick_1s;
    assign load_ok = load && (state_q != ST_RUN);
    assign is_one  = (min_t == '0) && (min_u == '0)
                  && (sec_t == '0) && (sec_u == 4'd1);

    bcd_down_digit #(.MOD(MOD_DEC)) u_sec_u (
        .clk       (clk),
        .rst       (rst),
        .en        (dec),
        .borrow_in (1'b1),
        .load      (load_ok),
        .load_val  (clamp_bcd(load_sec_u, 4'd9)),
        .digit     (sec_u),
        .borrow_out(b_su)
    );

    bcd_down_digit #(.MOD(MOD_SEX)) u_sec_t (
        .clk       (clk),
        .rst       (rst),
        .en        (dec),
        .borrow_in (b_su),
        .load      (load_ok),
        .load_val  (clamp_bcd(load_sec_t, 4'd5)),
        .digit     (sec_t),
        .borrow_out(b_st)
    );

    bcd_down_digit #(.MOD(MOD_DEC)) u_min_u (
        .clk       (clk),
        .rst       (rst),
        .en        (dec),
        .borrow_in (b_st),
        .load      (load_ok),
        .load_val  (clamp_bcd(load_min_u, 4'd9)),
        .digit     (min_u),
        .borrow_out(b_mu)
    );

    // The end of the borrow chain is high exactly when the count is 00:00.
    bcd_down_digit #(.MOD(MOD_DEC)) u_min_t (
        .clk       (clk),
        .rst       (rst),
        .en        (dec),
        .borrow_in (b_mu),
        .load      (load_ok),
        .load_val  (clamp_bcd(load_min_t, 4'd9)),
        .digit     (min_t),
        .borrow_out(is_zero)
    );

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_PAUSED: begin
                if (!load && start && !is_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick_1s && is_one) begin
                    state_d = ST_EXPIRED;
                    done_d  = 1'b1;
                    acnt_d  = '0;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_EXPIRED: begin
                if (load) begin
                    state_d = ST_IDLE;
                    acnt_d  = '0;
                end else if (tick_1s) begin
                    if (acnt_q + 4'd1 == ALARM_LIM) begin
                        state_d = ST_IDLE;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acnt_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: doc/countdown_timer_mmss.md
Name: countdown_timer_mmss

Overview:
- Consumer end of the 1 Hz tick produced by the 50 MHz frequency divider.
- Counts an MM:SS value down by one second per tick and drives four BCD digits for the 7-segment decoders.
- Raises a one-cycle done pulse and a timed alarm level at 00:00.
- Sits between the divider and the display/buzzer logic in the top level.

Parameters:
- ALARM_SECONDS, 5, number of ticks the alarm output stays high after expiry (1..15).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- tick_1s  in  1  one-clk-wide pulse once per second, from the divider.
- start  in  1  one-cycle command: begin or resume the countdown.
- pause  in  1  one-cycle command: freeze the countdown.
- load  in  1  one-cycle command: load load_* into the counter.
- load_min_t  in  4  BCD minutes tens.
- load_min_u  in  4  BCD minutes units.
- load_sec_t  in  4  BCD seconds tens.
- load_sec_u  in  4  BCD seconds units.
- min_t, min_u, sec_t, sec_u  out  4 each  current BCD digits, registered.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on expiry.
- alarm  out  1  high in EXPIRED.

Behaviour:
- Reset: state IDLE; all digits 0; running=0, done=0, alarm=0; alarm counter 0. Reset overrides every input, including mid-countdown.
- States: IDLE, RUN, PAUSED, EXPIRED. Two-bit encoding.
- Load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Digits are clamped on load: any digit >9 becomes 9; sec tens >5 becomes 5.
  - PAUSED stays PAUSED; EXPIRED goes to IDLE with alarm cleared.
  - Digits update on the cycle after load.
- Start:
  - IDLE or PAUSED -> RUN if the count is non-zero.
  - Ignored if the count is 00:00, and ignored in RUN and EXPIRED.
- Pause: RUN -> PAUSED; ignored in all other states.
- Same-cycle priority: load > start > pause. If load and start arrive together, the load is applied and start is dropped.
- Decrement, RUN only, on tick_1s:
  - sec_u-1; if sec_u=0 then sec_u=9 and borrow.
  - Borrow into sec_t: wraps 0->5.
  - Borrow into min_u: wraps 0->9.
  - Borrow into min_t: min_t-1.
  - The result is visible one clk after the tick.
- Expiry: a tick in RUN while the count is 00:01 gives 00:00, state EXPIRED, done=1 for exactly one cycle (the same cycle the digits show 00:00), and alarm=1.
- Tick timing across transitions:
  - A tick arriving in the same cycle as an IDLE/PAUSED->RUN transition is not counted.
  - A tick arriving together with pause in RUN is counted, then the state becomes PAUSED.
  - If that counted tick reaches 00:00, EXPIRED wins over PAUSED.
- EXPIRED:
  - The alarm counter increments on each tick_1s.
  - When it reaches ALARM_SECONDS: alarm=0, state IDLE, counter cleared, digits stay 00:00.
- Ticks arriving in IDLE or PAUSED are ignored.
- Maximum count 99:59. No wrap below 00:00: expiry always happens first.

Decomposition:
- Shared package timer_pkg:
  - State encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSED=2, ST_EXPIRED=3.
  - BCD width 4.
  - Digit moduli 10 and 6.
- Sub-module bcd_down_digit:
  - Parameter MOD (10 or 6).
  - Inputs: en, borrow_in, load, load_val.
  - Outputs: digit, borrow_out = (digit==0)&borrow_in.
- Instantiated four times, chained on borrow.

Test Plan:
- Reset mid-run: load 00:10, start, 3 ticks, assert rst -> digits 00:00, state IDLE, running=0, alarm=0 on the next cycle.
- Load 01:00, start, 1 tick -> 00:59; 59 more ticks -> done pulses once for 1 cycle, digits 00:00, alarm=1; 5 more ticks -> alarm=0, IDLE.
- Pause/resume: load 00:05, start, 2 ticks (00:03), pause, 4 ticks -> still 00:03; start, 1 tick -> 00:02.
- Clamp and borrow chain:
  - Load min_t=1, min_u=0, sec_t=7, sec_u=12 -> digits 10:59.
  - Start, 1 tick -> 10:58.
  - Separately, load 10:00, 1 tick -> 09:59.
- Simultaneous events:
  - load+start in IDLE -> loaded, running=0.
  - start at 00:00 -> stays IDLE.
  - tick+pause at 00:01 -> EXPIRED, done=1.
  - tick on the start cycle -> not counted.
- Load in RUN ignored: load 00:30, start, then load 05:00 -> digits keep counting down from 00:30.
